// File: rtl/vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// vga_frame_monitor
//
// Passive checker for a clocked-video stream (syncs + datavalid + 24-bit RGB).
// It sits alongside the VGA pins and, frame by frame, measures line period,
// active pixels per line, active lines per frame and a wrapping pixel checksum.
// `locked` is raised once enough consecutive frames match the expected geometry.
//
// Ports
//   clk_65          pixel clock; everything runs on its rising edge
//   reset           synchronous, active-high
//   vid_data        {R,G,B} pixel
//   vid_datavalid   pixel valid
//   vid_h_sync      horizontal sync (polarity set by SYNC_ACTIVE_LOW)
//   vid_v_sync      vertical sync   (polarity set by SYNC_ACTIVE_LOW)
//   h_total_meas    clocks between the last two hsync leading edges (saturating)
//   h_active_meas   pixel count of the last active line of the last frame
//   v_active_meas   active lines in the last complete frame
//   frame_checksum  wrapping sum of valid pixels of the last complete frame
//   frame_count     complete frames seen (wraps)
//   frame_pulse     one-cycle strobe when the measurement outputs update
//   line_mismatch   last complete frame had active lines of unequal length
//   locked          geometry lock
// -----------------------------------------------------------------------------
module vga_frame_monitor #(
    parameter int H_ACTIVE        = 1024,
    parameter int V_ACTIVE        = 768,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 2,
    parameter int TIMEOUT_CYCLES  = 4194303
) (
    input  logic        clk_65,
    input  logic        reset,
    input  logic [23:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_h_sync,
    input  logic        vid_v_sync,
    output logic [11:0] h_total_meas,
    output logic [11:0] h_active_meas,
    output logic [11:0] v_active_meas,
    output logic [23:0] frame_checksum,
    output logic [15:0] frame_count,
    output logic        frame_pulse,
    output logic        line_mismatch,
    output logic        locked
);

    localparam int             VTO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [VTO_W-1:0] VTO_MAX = VTO_W'(TIMEOUT_CYCLES);
    localparam logic [11:0]    H_ACT12 = 12'(H_ACTIVE);
    localparam logic [11:0]    V_ACT12 = 12'(V_ACTIVE);
    localparam logic [4:0]     LOCK5   = 5'(LOCK_FRAMES);

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Syncs are normalised before capture so a registered 1 always means active.
    logic hs_norm, vs_norm;
    assign hs_norm = SYNC_ACTIVE_LOW ? ~vid_h_sync : vid_h_sync;
    assign vs_norm = SYNC_ACTIVE_LOW ? ~vid_v_sync : vid_v_sync;

    // Capture stages: only the syncs need the second stage (edge detect);
    // pixel data and datavalid are consumed straight from s1.
    logic [23:0] data_s1;
    logic        dv_s1;
    logic        hs_s1, hs_s2;
    logic        vs_s1, vs_s2;

    logic hs_edge, vs_edge;
    assign hs_edge = hs_s1 & ~hs_s2;
    assign vs_edge = vs_s1 & ~vs_s2;

    // Measurement state
    logic [11:0]      hclk;
    logic             hs_seen;
    logic [11:0]      pix;
    logic [11:0]      lines;
    logic [11:0]      last_pix;
    logic [11:0]      first_pix;
    logic             have_first;
    logic             mismatch;
    logic [23:0]      sum;
    logic             armed;
    logic [3:0]       run;
    logic [VTO_W-1:0] vto;

    // Line close. Evaluated combinationally so that a vsync edge in the same
    // cycle sees the just-closed line as part of the frame it is closing.
    logic [11:0] lines_c, last_pix_c, first_pix_c;
    logic        have_first_c, mismatch_c, good_c;

    always_comb begin
        lines_c      = lines;
        last_pix_c   = last_pix;
        first_pix_c  = first_pix;
        have_first_c = have_first;
        mismatch_c   = mismatch;
        if ((hs_edge || vs_edge) && (pix != 12'd0)) begin
            lines_c    = sat_inc12(lines);
            last_pix_c = pix;
            if (!have_first) begin
                first_pix_c  = pix;
                have_first_c = 1'b1;
            end else if (pix != first_pix) begin
                mismatch_c = 1'b1;
            end
        end
        good_c = (last_pix_c == H_ACT12) && (lines_c == V_ACT12) && !mismatch_c;
    end

    always_ff @(posedge clk_65) begin
        if (reset) begin
            data_s1        <= '0;
            dv_s1          <= 1'b0;
            hs_s1          <= 1'b0;
            hs_s2          <= 1'b0;
            vs_s1          <= 1'b0;
            vs_s2          <= 1'b0;
            hclk           <= '0;
            hs_seen        <= 1'b0;
            pix            <= '0;
            lines          <= '0;
            last_pix       <= '0;
            first_pix      <= '0;
            have_first     <= 1'b0;
            mismatch       <= 1'b0;
            sum            <= '0;
            armed          <= 1'b0;
            run            <= '0;
            vto            <= '0;
            h_total_meas   <= '0;
            h_active_meas  <= '0;
            v_active_meas  <= '0;
            frame_checksum <= '0;
            frame_count    <= '0;
            frame_pulse    <= 1'b0;
            line_mismatch  <= 1'b0;
            locked         <= 1'b0;
        end else begin
            // ---- capture stages ----
            data_s1 <= vid_data;
            dv_s1   <= vid_datavalid;
            hs_s1   <= hs_norm;
            hs_s2   <= hs_s1;
            vs_s1   <= vs_norm;
            vs_s2   <= vs_s1;

            // ---- measurement stage (works on s1/s2) ----
            frame_pulse <= 1'b0;

            // Line period; the very first hsync has no reference so is skipped.
            if (hs_edge) begin
                hclk    <= '0;
                hs_seen <= 1'b1;
                if (hs_seen)
                    h_total_meas <= sat_inc12(hclk);
            end else begin
                hclk <= sat_inc12(hclk);
            end

            // The datavalid of an edge cycle belongs to the newly opened line.
            if (hs_edge || vs_edge)
                pix <= {11'd0, dv_s1};
            else if (dv_s1)
                pix <= sat_inc12(pix);

            lines      <= lines_c;
            last_pix   <= last_pix_c;
            first_pix  <= first_pix_c;
            have_first <= have_first_c;
            mismatch   <= mismatch_c;

            // The pixel on a vsync edge cycle opens the new frame's checksum.
            if (vs_edge)
                sum <= dv_s1 ? data_s1 : 24'd0;
            else if (dv_s1)
                sum <= sum + data_s1;

            if (vs_edge) begin
                // vto reads as clocks elapsed since the edge cycle.
                vto        <= VTO_W'(1);
                lines      <= '0;
                mismatch   <= 1'b0;
                have_first <= 1'b0;
                if (!armed) begin
                    // First frame boundary after reset/timeout: nothing to report.
                    armed <= 1'b1;
                end else begin
                    h_active_meas  <= last_pix_c;
                    v_active_meas  <= lines_c;
                    line_mismatch  <= mismatch_c;
                    frame_checksum <= sum;
                    frame_count    <= frame_count + 16'd1;
                    frame_pulse    <= 1'b1;
                    if (good_c) begin
                        run <= sat_inc4(run);
                        if (({1'b0, run} + 5'd1) >= LOCK5)
                            locked <= 1'b1;
                    end else begin
                        run    <= '0;
                        locked <= 1'b0;
                    end
                end
            end else if (vto == VTO_MAX) begin
                // Stream lost: hold the counter and drop lock until vsync returns.
                locked <= 1'b0;
                run    <= '0;
                armed  <= 1'b0;
            end else begin
                vto <= vto + VTO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_monitor
//
// Directed bench for vga_frame_monitor with a small geometry (8x4 active,
// 12 clocks per line, 6 lines per frame) plus 1024-pixel wide lines
// (1344 clocks). Expected per-frame reports are queued before the frame that
// closes them is driven; a monitor pops one entry per frame_pulse.
//
// Frame layout (y = line 0..5, x = clock within line):
//   hsync active for x<2; active lines y=2..5; pixels at x=2..; value (y-2)*16+(x-2)
//   vsync leading edge at (y=0,x=4), or at (y=0,x=0) for the simultaneous-edge frame
// Checksums: 8x4 frame   = 128*(0+1+2+3) + 4*(0+..+7)        = 880
//            short line  = 880 - (16*1+7)                     = 857
//            1024x4 wide = 16384*6 + 4*(1023*1024/2)          = 2193408
//            sim frame   = 880 + 0x100000                     = 1049456
// -----------------------------------------------------------------------------
module tb_vga_frame_monitor;

    localparam int TO        = 9000;
    localparam int CS_GOOD   = 880;
    localparam int CS_SHORT  = 857;
    localparam int CS_WIDE   = 2193408;
    localparam logic [23:0] EXTRA = 24'h100000;
    localparam int CS_SIM    = 1049456;

    logic        clk_65 = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] vid_data = '0;
    logic        vid_datavalid = 1'b0;
    logic        vid_h_sync = 1'b1;
    logic        vid_v_sync = 1'b1;
    logic [11:0] h_total_meas, h_active_meas, v_active_meas;
    logic [23:0] frame_checksum;
    logic [15:0] frame_count;
    logic        frame_pulse, line_mismatch, locked;

    always #5 clk_65 = ~clk_65;

    vga_frame_monitor #(
        .H_ACTIVE(8), .V_ACTIVE(4), .SYNC_ACTIVE_LOW(1'b1),
        .LOCK_FRAMES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_65(clk_65), .reset(reset),
        .vid_data(vid_data), .vid_datavalid(vid_datavalid),
        .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
        .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
        .v_active_meas(v_active_meas), .frame_checksum(frame_checksum),
        .frame_count(frame_count), .frame_pulse(frame_pulse),
        .line_mismatch(line_mismatch), .locked(locked)
    );

    typedef struct {
        logic [11:0] ht, ha, va;
        logic [23:0] cs;
        logic [15:0] fc;
        logic        mm, lk;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_pass = 0;
    int     n_checks = 0;
    longint cyc = 0;
    longint vs_drive_cyc = 0;

    always @(posedge clk_65) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    task automatic expect_frame(input int ht, input int ha, input int va, input int cs,
                                input int fc, input bit mm, input bit lk);
        exp_t e;
        e.ht = 12'(ht); e.ha = 12'(ha); e.va = 12'(va); e.cs = 24'(cs);
        e.fc = 16'(fc); e.mm = mm; e.lk = lk;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk_65) begin
        if (frame_pulse) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: frame_count=%0d, no report expected", frame_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("h_total",  32'(h_total_meas),   32'(mon_e.ht));
                check("h_active", 32'(h_active_meas),  32'(mon_e.ha));
                check("v_active", 32'(v_active_meas),  32'(mon_e.va));
                check("checksum", 32'(frame_checksum), 32'(mon_e.cs));
                check("frame_count", 32'(frame_count), 32'(mon_e.fc));
                check("mismatch", 32'(line_mismatch),  32'(mon_e.mm));
                check("locked",   32'(locked),         32'(mon_e.lk));
            end
        end
    end

    // Drives one 6-line frame; called and returns at posedge+1.
    task automatic send_frame(input int ht, input int ha, input int short_y,
                              input bit sim, input logic [23:0] extra);
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < ht; x++) begin
                bit          vs_act;
                bit          dv;
                int          len;
                logic [23:0] d;
                vs_act = sim ? (y == 0) : (y == 0 && x >= 4);
                if (y == 0 && ((sim && x == 0) || (!sim && x == 4)))
                    vs_drive_cyc = cyc;
                len = (y == short_y) ? ha - 1 : ha;
                dv  = (y >= 2) && (x >= 2) && (x < 2 + len);
                d   = dv ? 24'((y - 2) * 16 + (x - 2)) : 24'hABCDEF;
                if (sim && y == 0 && x == 0) begin
                    dv = 1'b1;
                    d  = extra;
                end
                vid_h_sync    = (x < 2) ? 1'b0 : 1'b1;
                vid_v_sync    = ~vs_act;
                vid_datavalid = dv;
                vid_data      = d;
                @(posedge clk_65); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        vid_h_sync = 1'b1; vid_v_sync = 1'b1; vid_datavalid = 1'b0; vid_data = '0;
        repeat (n) begin @(posedge clk_65); #1; end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h_total"},  32'(h_total_meas),   0);
        check({tag, "_h_active"}, 32'(h_active_meas),  0);
        check({tag, "_v_active"}, 32'(v_active_meas),  0);
        check({tag, "_checksum"}, 32'(frame_checksum), 0);
        check({tag, "_fcount"},   32'(frame_count),    0);
        check({tag, "_pulse"},    32'(frame_pulse),    0);
        check({tag, "_mismatch"}, 32'(line_mismatch),  0);
        check({tag, "_locked"},   32'(locked),         0);
    endtask

    initial begin
        repeat (80000) @(posedge clk_65);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint target;
        // Reset state
        repeat (3) @(posedge clk_65);
        @(negedge clk_65);
        check_all_zero("reset");
        @(posedge clk_65); #1;
        reset = 1'b0;
        idle(4);

        // Three good frames: arm, report (unlocked), report (locked)
        send_frame(12, 8, -1, 1'b0, '0);
        expect_frame(12, 8, 4, CS_GOOD, 1, 1'b0, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        expect_frame(12, 8, 4, CS_GOOD, 2, 1'b0, 1'b1);
        send_frame(12, 8, -1, 1'b0, '0);

        // Short line on y=3 -> mismatch, lock dropped, relock after two good frames
        expect_frame(12, 8, 4, CS_GOOD, 3, 1'b0, 1'b1);
        send_frame(12, 8, 3, 1'b0, '0);
        expect_frame(12, 8, 4, CS_SHORT, 4, 1'b1, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        expect_frame(12, 8, 4, CS_GOOD, 5, 1'b0, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        expect_frame(12, 8, 4, CS_GOOD, 6, 1'b0, 1'b1);
        send_frame(12, 8, -1, 1'b0, '0);
        check("pending_lock", 32'(exp_q.size()), 0);

        // Simultaneous hsync/vsync edges with a valid pixel on that cycle:
        // the closing line stays in the old frame, the pixel opens the new one
        // (one-pixel line -> 5 lines and a mismatch in the new frame).
        expect_frame(12, 8, 4, CS_GOOD, 7, 1'b0, 1'b1);
        send_frame(12, 8, -1, 1'b1, EXTRA);
        expect_frame(12, 8, 5, CS_SIM, 8, 1'b1, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        check("pending_sim", 32'(exp_q.size()), 0);

        // Full-width 1024-pixel lines at 1344 clocks
        expect_frame(12, 8, 4, CS_GOOD, 9, 1'b0, 1'b0);
        send_frame(1344, 1024, -1, 1'b0, '0);
        expect_frame(1344, 1024, 4, CS_WIDE, 10, 1'b0, 1'b0);
        send_frame(1344, 1024, -1, 1'b0, '0);
        expect_frame(1344, 1024, 4, CS_WIDE, 11, 1'b0, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        expect_frame(12, 8, 4, CS_GOOD, 12, 1'b0, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        expect_frame(12, 8, 4, CS_GOOD, 13, 1'b0, 1'b1);
        send_frame(12, 8, -1, 1'b0, '0);
        check("pending_wide", 32'(exp_q.size()), 0);

        // Vsync stops: lock must drop at the clock edge ending the cycle
        // TO clocks after the last vsync edge cycle (input seen at +1, edge cycle +1).
        vid_h_sync = 1'b1; vid_v_sync = 1'b1; vid_datavalid = 1'b0;
        target = vs_drive_cyc + 1 + TO;
        do @(negedge clk_65); while (cyc < target);
        check("locked_before_timeout", 32'(locked), 1);
        @(negedge clk_65);
        check("locked_at_timeout", 32'(locked), 0);
        check("fcount_kept", 32'(frame_count), 13);
        check("h_active_kept", 32'(h_active_meas), 8);
        @(posedge clk_65); #1;

        // Resume: first edge only re-arms, second reports with run restarted
        send_frame(12, 8, -1, 1'b0, '0);
        check("fcount_after_rearm", 32'(frame_count), 13);
        expect_frame(12, 8, 4, CS_GOOD, 14, 1'b0, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        check("pending_resume", 32'(exp_q.size()), 0);

        // Reset in the middle of an open frame
        reset = 1'b1;
        vid_h_sync = 1'b1; vid_v_sync = 1'b1; vid_datavalid = 1'b0;
        @(posedge clk_65); #1;
        reset = 1'b0;
        @(negedge clk_65);
        check_all_zero("midreset");
        @(posedge clk_65); #1;
        send_frame(12, 8, -1, 1'b0, '0);
        idle(5000);
        check("fcount_after_arm", 32'(frame_count), 0);
        // Hsync gap of ~5000 clocks saturates the line period measurement.
        expect_frame(4095, 8, 4, CS_GOOD, 1, 1'b0, 1'b0);
        send_frame(12, 8, -1, 1'b0, '0);
        idle(4);
        check("pending_end", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
